// File: rtl/exe_stage_if.sv
// Execute-stage bundle: ID/EXE operands and forwarding inputs in, ALU/branch results out.
// The slave modport is the execute stage; the master modport is whoever drives the ID/EXE register.
interface exe_stage_if;
  logic [3:0]  EXE_CMD;
  logic [1:0]  Br_type;
  logic [31:0] PC_in;
  logic [31:0] Val1;
  logic [31:0] Val2;
  logic [31:0] Reg2;
  logic [1:0]  sel_src1;
  logic [1:0]  sel_src2;
  logic [31:0] MEM_fwd;
  logic [31:0] WB_fwd;
  logic [31:0] ALU_result;
  logic [31:0] ST_val;
  logic [31:0] Br_addr;
  logic        Br_taken;
  logic        exe_busy;
  // Multiplier FSM state for observation: 0 idle, 1 run, 2 done (always 0 without the multiplier).
  logic [1:0]  dbg_state;

  // No valid/ready pair: the stage is combinational except for the multiplier, and
  // exe_busy=1 means "freeze ID/EXE and insert a bubble into EXE/MEM this cycle".
  modport slave (
    input  EXE_CMD, Br_type, PC_in, Val1, Val2, Reg2,
    input  sel_src1, sel_src2, MEM_fwd, WB_fwd,
    output ALU_result, ST_val, Br_addr, Br_taken, exe_busy, dbg_state
  );

  modport master (
    output EXE_CMD, Br_type, PC_in, Val1, Val2, Reg2,
    output sel_src1, sel_src2, MEM_fwd, WB_fwd,
    input  ALU_result, ST_val, Br_addr, Br_taken, exe_busy, dbg_state
  );
endinterface

// File: rtl/exe_stage.sv
// Pipeline execute stage: operand forwarding, ALU, branch resolution.
// Define EXE_MULT_EN to build the 32-cycle shift-add multiplier for opcode 1011.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  exe_stage_if.slave  bus
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_NOR = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1011;

  localparam logic [1:0] BR_BEZ  = 2'b00;
  localparam logic [1:0] BR_BNE  = 2'b01;
  localparam logic [1:0] BR_JMP  = 2'b10;

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] op_s;
  logic [31:0] alu_res;
  logic [4:0]  shamt;
  logic        br_taken;
  logic        mul_done;
  logic [31:0] mul_res;
  logic        busy;
  logic [1:0]  state_dbg;

  assign op_b  = bus.Val2;
  assign shamt = op_b[4:0];

  always_comb begin
    op_a = bus.Val1;
    case (bus.sel_src1)
      2'b01:   op_a = bus.MEM_fwd;
      2'b10:   op_a = bus.WB_fwd;
      default: op_a = bus.Val1;
    endcase
  end

  always_comb begin
    op_s = bus.Reg2;
    case (bus.sel_src2)
      2'b01:   op_s = bus.MEM_fwd;
      2'b10:   op_s = bus.WB_fwd;
      default: op_s = bus.Reg2;
    endcase
  end

  // MUL is absent here on purpose: its result only appears through the DONE override.
  always_comb begin
    alu_res = 32'd0;
    case (bus.EXE_CMD)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_NOR:  alu_res = ~(op_a | op_b);
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      OP_SRL:  alu_res = op_a >> shamt;
      default: alu_res = 32'd0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (bus.Br_type)
      BR_BEZ:  br_taken = (op_a == 32'd0);
      BR_BNE:  br_taken = (op_a != op_s);
      BR_JMP:  br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

`ifdef EXE_MULT_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

  mult_state_e state_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [31:0] acc_q;
  logic [31:0] acc_d;
  logic [4:0]  cnt_q;
  logic        run_q;
  logic        done_q;
  logic        mul_start;

  assign mul_start = (state_q == ST_IDLE) && (bus.EXE_CMD == OP_MUL);
  assign acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      acc_q    <= 32'd0;
      cnt_q    <= 5'd0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (mul_start) begin
            mcand_q  <= op_a;
            mplier_q <= op_b;
            acc_q    <= 32'd0;
            cnt_q    <= 5'd0;
            run_q    <= 1'b1;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            run_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          run_q   <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // The start cycle must already freeze upstream, so busy combines the registered RUN flag with the request.
  assign busy      = run_q | mul_start;
  assign mul_done  = done_q;
  assign mul_res   = acc_q;
  assign state_dbg = state_q;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign busy           = 1'b0;
  assign mul_done       = 1'b0;
  assign mul_res        = 32'd0;
  assign state_dbg      = 2'd0;
`endif

  assign bus.ALU_result = mul_done ? mul_res : alu_res;
  assign bus.ST_val     = op_s;
  assign bus.Br_addr    = bus.PC_in + (bus.Val2 << 2);
  assign bus.Br_taken   = br_taken;
  assign bus.exe_busy   = busy;
  assign bus.dbg_state  = state_dbg;

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage (ALU, forwarding, branches, optional multiplier).
module tb_exe_stage;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  exe_stage_if bus ();

  exe_stage u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic drive(input logic [3:0] cmd, input logic [1:0] bt, input logic [31:0] pc,
                       input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] r2,
                       input logic [1:0] s1, input logic [1:0] s2,
                       input logic [31:0] mf, input logic [31:0] wf);
    bus.EXE_CMD  = cmd;
    bus.Br_type  = bt;
    bus.PC_in    = pc;
    bus.Val1     = v1;
    bus.Val2     = v2;
    bus.Reg2     = r2;
    bus.sel_src1 = s1;
    bus.sel_src2 = s2;
    bus.MEM_fwd  = mf;
    bus.WB_fwd   = wf;
  endtask

  // Apply one vector just after a rising edge and settle before checking.
  task automatic vec(input logic [3:0] cmd, input logic [1:0] bt, input logic [31:0] pc,
                     input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] r2,
                     input logic [1:0] s1, input logic [1:0] s2,
                     input logic [31:0] mf, input logic [31:0] wf);
    @(posedge clk);
    #1;
    drive(cmd, bt, pc, v1, v2, r2, s1, s2, mf, wf);
    #1;
  endtask

`ifdef EXE_MULT_EN
  // Present a MUL in an idle cycle, count busy cycles, check the DONE cycle.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit disturb);
    int n;
    vec(4'b1011, 2'b11, 32'd0, a, b, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0);
    chk({tag, "_busy_start"}, {31'd0, bus.exe_busy}, 32'd1);
    n = 0;
    while (bus.exe_busy === 1'b1 && n < 40) begin
      n++;
      @(posedge clk);
      #2;
      if (disturb && n == 5) begin
        bus.sel_src1 = 2'b01;
        bus.MEM_fwd  = 32'd0;
      end
    end
    chk({tag, "_busy_cycles"}, n, 32'd33);
    chk({tag, "_done_busy"}, {31'd0, bus.exe_busy}, 32'd0);
    chk({tag, "_result"}, bus.ALU_result, exp);
  endtask
`endif

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    drive(4'd0, 2'b11, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", {31'd0, bus.exe_busy}, 32'd0);
    chk("rst_alu", bus.ALU_result, 32'd0);
    chk("rst_st", bus.ST_val, 32'd0);
    chk("rst_braddr", bus.Br_addr, 32'd0);
    chk("rst_brtaken", {31'd0, bus.Br_taken}, 32'd0);
    rst = 1'b0;

    // ALU operations
    vec(4'b0000, 2'b11, 32'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0);
    chk("add_ovf", bus.ALU_result, 32'h8000_0000);
    vec(4'b1001, 2'b11, 32'd0, 32'h8000_0000, 32'd4, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0);
    chk("sra", bus.ALU_result, 32'hF800_0000);
    vec(4'b1010, 2'b11, 32'd0, 32'h8000_0000, 32'd4, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0);
    chk("srl", bus.ALU_result, 32'h0800_0000);
    vec(4'b1000, 2'b11, 32'd0, 32'd1, 32'h0000_003F, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0);
    chk("sll_b40", bus.ALU_result, 32'h8000_0000);
    vec(4'b0010, 2'b11, 32'd0, 32'd5, 32'd7, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0);
    chk("sub_neg", bus.ALU_result, 32'hFFFF_FFFE);
    vec(4'b0100, 2'b11, 32'd0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0);
    chk("and", bus.ALU_result, 32'h00F0_000F);
    bus.EXE_CMD = 4'b0101;
    #1;
    chk("or", bus.ALU_result, 32'hFFF0_0FFF);
    bus.EXE_CMD = 4'b0110;
    #1;
    chk("nor", bus.ALU_result, 32'h000F_F000);
    bus.EXE_CMD = 4'b0111;
    #1;
    chk("xor", bus.ALU_result, 32'hFF00_0FF0);
    bus.EXE_CMD = 4'b0001;
    #1;
    chk("undef_op", bus.ALU_result, 32'd0);

    // Forwarding onto A
    vec(4'b0000, 2'b11, 32'd0, 32'd1, 32'd1, 32'd0, 2'b01, 2'b00, 32'd5, 32'd9);
    chk("fwd_mem", bus.ALU_result, 32'd6);
    bus.sel_src1 = 2'b10;
    #1;
    chk("fwd_wb", bus.ALU_result, 32'd10);
    bus.sel_src1 = 2'b11;
    #1;
    chk("fwd_sel11", bus.ALU_result, 32'd2);

    // Branches
    vec(4'b0000, 2'b01, 32'h100, 32'd3, 32'd2, 32'd0, 2'b00, 2'b01, 32'd3, 32'd0);
    chk("bne_equal", {31'd0, bus.Br_taken}, 32'd0);
    chk("br_addr", bus.Br_addr, 32'h108);
    bus.MEM_fwd = 32'd4;
    #1;
    chk("bne_diff", {31'd0, bus.Br_taken}, 32'd1);
    chk("st_fwd_mem", bus.ST_val, 32'd4);
    bus.sel_src2 = 2'b10;
    bus.WB_fwd   = 32'h0000_0ABC;
    #1;
    chk("st_fwd_wb", bus.ST_val, 32'h0000_0ABC);
    bus.Br_type = 2'b11;
    #1;
    chk("br_none", {31'd0, bus.Br_taken}, 32'd0);
    vec(4'b0000, 2'b00, 32'h100, 32'd0, 32'hFFFF_FFFF, 32'd7, 2'b00, 2'b00, 32'd0, 32'd0);
    chk("bez_zero", {31'd0, bus.Br_taken}, 32'd1);
    chk("br_addr_neg", bus.Br_addr, 32'h0000_00FC);
    bus.Val1 = 32'd1;
    #1;
    chk("bez_nonzero", {31'd0, bus.Br_taken}, 32'd0);
    bus.Br_type = 2'b10;
    #1;
    chk("jmp", {31'd0, bus.Br_taken}, 32'd1);

`ifdef EXE_MULT_EN
    run_mul("mul_neg1x3", 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b1);
    run_mul("mul_7x6", 32'd7, 32'd6, 32'd42, 1'b0);

    // Reset in the middle of a multiply
    vec(4'b1011, 2'b11, 32'd0, 32'd5, 32'd5, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0);
    repeat (11) @(posedge clk);
    #2;
    chk("mid_busy", {31'd0, bus.exe_busy}, 32'd1);
    rst = 1'b1;
    drive(4'd0, 2'b11, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0);
    @(posedge clk);
    #2;
    chk("abort_busy", {31'd0, bus.exe_busy}, 32'd0);
    chk("abort_alu", bus.ALU_result, 32'd0);
    rst = 1'b0;
    run_mul("mul_2x2", 32'd2, 32'd2, 32'd4, 1'b0);
    vec(4'b0000, 2'b11, 32'd0, 32'd3, 32'd4, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0);
    chk("post_mul_add", bus.ALU_result, 32'd7);
    chk("post_mul_busy", {31'd0, bus.exe_busy}, 32'd0);
`else
    vec(4'b1011, 2'b11, 32'd0, 32'hFFFF_FFFF, 32'd3, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0);
    chk("nomul_alu", bus.ALU_result, 32'd0);
    chk("nomul_busy", {31'd0, bus.exe_busy}, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    chk("nomul_busy_later", {31'd0, bus.exe_busy}, 32'd0);
    chk("nomul_alu_later", bus.ALU_result, 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
